huffman_block_sequencer: RTL and testbench

Sequences one Huffman_Decoder instance through a full 8x8 JPEG block of entropy-coded data. Pulls bits from an upstream bitstream handshake, feeds them one at a time to the decoder, and collects magnitude (extra) bits after each decoded symbol. Converts the magnitude bits to signed coefficients and emits them with their zig-zag index. Handles EOB and ZRL. Sits between the bitstream/marker unit and the dequantiser.

---
 rtl/huffman_block_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_huffman_block_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_block_sequencer.sv
// Sequences one Huffman_Decoder through an 8x8 JPEG block: feeds code bits, gathers
// magnitude bits, rebuilds signed coefficients and emits them with their zig-zag index.
module huffman_block_sequencer #(
   parameter int COEF_W       = 12,
   parameter int MAX_CODE_LEN = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              bit_valid,
   input  logic              bit_data,
   output logic              bit_ready,
   output logic              hd_rst,
   output logic              hd_ac_dc_flag,
   output logic              hd_next_bit,
   output logic              hd_is_new,
   input  logic [3:0]        hd_s_value,
   input  logic [3:0]        hd_r_value,
   input  logic              hd_done,
   output logic              coef_valid,
   output logic [5:0]        coef_index,
   output logic [COEF_W-1:0] coef_value,
   output logic              block_done,
   output logic              error
);

   localparam int CL_W = $clog2(MAX_CODE_LEN + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_CLR, S_FEED, S_WAIT, S_EXTRA, S_EMIT, S_ADV, S_FIN, S_ERR
   } state_t;

   state_t              state_q, state_d;
   logic                dc_phase_q, dc_phase_d;
   logic [6:0]          index_q, index_d;
   logic [3:0]          run_q, run_d;
   logic [3:0]          size_q, size_d;
   logic [14:0]         extra_q, extra_d;
   logic [3:0]          extra_cnt_q, extra_cnt_d;
   logic [CL_W-1:0]     code_len_q, code_len_d;
   logic                hd_rst_q, hd_rst_d;
   logic                coef_valid_q, coef_valid_d;
   logic [5:0]          coef_index_q, coef_index_d;
   logic [COEF_W-1:0]   coef_value_q, coef_value_d;
   logic                block_done_q, block_done_d;
   logic                error_q, error_d;

   logic [COEF_W-1:0]   span;
   logic                extra_msb;
   logic [COEF_W-1:0]   emit_value;
   logic [6:0]          target;
   logic [6:0]          zrl_sum;

   // Bit handshake and decoder strobes follow the registered state so a bit offered in
   // FEED reaches the decoder on the same edge the sequencer accepts it.
   assign bit_ready     = (state_q == S_FEED) || ((state_q == S_EXTRA) && (size_q != 4'd0));
   assign hd_is_new     = (state_q == S_FEED) && bit_valid;
   assign hd_next_bit   = hd_is_new && bit_data;
   assign hd_ac_dc_flag = dc_phase_q && (state_q != S_IDLE);

   assign hd_rst        = hd_rst_q;
   assign coef_valid    = coef_valid_q;
   assign coef_index    = coef_index_q;
   assign coef_value    = coef_value_q;
   assign block_done    = block_done_q;
   assign error         = error_q;

   // A leading 0 in the magnitude bits marks a negative value stored as value + (2^size - 1).
   assign span       = (COEF_W'(1) << size_q) - COEF_W'(1);
   assign extra_msb  = (size_q != 4'd0) && extra_q[size_q - 4'd1];
   assign emit_value = (size_q == 4'd0) ? '0 :
                       extra_msb        ? extra_q[COEF_W-1:0] :
                                          extra_q[COEF_W-1:0] - span;
   assign target     = index_q + {3'b000, run_q};
   assign zrl_sum    = index_q + 7'd16;

   always_comb begin
      // NOTE: every _d starts from its _q (or a zero strobe) so no path leaves a latch.
      state_d      = state_q;
      dc_phase_d   = dc_phase_q;
      index_d      = index_q;
      run_d        = run_q;
      size_d       = size_q;
      extra_d      = extra_q;
      extra_cnt_d  = extra_cnt_q;
      code_len_d   = code_len_q;
      coef_valid_d = 1'b0;
      coef_index_d = coef_index_q;
      coef_value_d = coef_value_q;
      error_d      = error_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_CLR;
               dc_phase_d = 1'b1;
               index_d    = 7'd0;
               error_d    = 1'b0;
            end
         end
         S_CLR: begin
            code_len_d  = '0;
            extra_d     = '0;
            extra_cnt_d = 4'd0;
            state_d     = S_FEED;
         end
         S_FEED: begin
            if (bit_valid) begin
               code_len_d = code_len_q + CL_W'(1);
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (hd_done) begin
               run_d   = hd_s_value;
               size_d  = hd_r_value;
               state_d = S_EXTRA;
            end else if (code_len_q == CL_W'(MAX_CODE_LEN)) begin
               state_d = S_ERR;
            end else begin
               state_d = S_FEED;
            end
         end
         S_EXTRA: begin
            if (size_q == 4'd0) begin
               state_d = S_EMIT;
            end else if (bit_valid) begin
               extra_d     = {extra_q[13:0], bit_data};
               extra_cnt_d = extra_cnt_q + 4'd1;
               if (extra_cnt_q + 4'd1 == size_q) state_d = S_EMIT;
            end
         end
         S_EMIT: begin
            if (int'(size_q) > COEF_W - 1) begin
               state_d = S_ERR;
            end else if (dc_phase_q) begin
               coef_valid_d = 1'b1;
               coef_index_d = 6'd0;
               coef_value_d = emit_value;
               dc_phase_d   = 1'b0;
               index_d      = 7'd1;
               state_d      = S_CLR;
            end else if ((run_q == 4'd0) && (size_q == 4'd0)) begin
               state_d = S_FIN;
            end else if ((run_q == 4'd15) && (size_q == 4'd0)) begin
               if (zrl_sum > 7'd63) begin
                  state_d = S_ERR;
               end else begin
                  index_d = zrl_sum;
                  state_d = S_ADV;
               end
            end else if (target > 7'd63) begin
               state_d = S_ERR;
            end else begin
               coef_valid_d = 1'b1;
               coef_index_d = target[5:0];
               coef_value_d = emit_value;
               index_d      = target + 7'd1;
               state_d      = S_ADV;
            end
         end
         S_ADV:   state_d = (index_q == 7'd64) ? S_FIN : S_CLR;
         S_FIN:   state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      hd_rst_d     = (state_d == S_CLR);
      block_done_d = (state_d == S_FIN);
      if (state_d == S_ERR) error_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         dc_phase_q   <= 1'b0;
         index_q      <= 7'd0;
         run_q        <= 4'd0;
         size_q       <= 4'd0;
         extra_q      <= '0;
         extra_cnt_q  <= 4'd0;
         code_len_q   <= '0;
         hd_rst_q     <= 1'b0;
         coef_valid_q <= 1'b0;
         coef_index_q <= 6'd0;
         coef_value_q <= '0;
         block_done_q <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values of its peers.
         state_q      <= state_d;
         dc_phase_q   <= dc_phase_d;
         index_q      <= index_d;
         run_q        <= run_d;
         size_q       <= size_d;
         extra_q      <= extra_d;
         extra_cnt_q  <= extra_cnt_d;
         code_len_q   <= code_len_d;
         hd_rst_q     <= hd_rst_d;
         coef_valid_q <= coef_valid_d;
         coef_index_q <= coef_index_d;
         coef_value_q <= coef_value_d;
         block_done_q <= block_done_d;
         error_q      <= error_d;
      end
   end

endmodule

// File: tb/tb_huffman_block_sequencer.sv
// Scoreboard bench: blocks are built as symbol lists, encoded to a bitstream with a
// small JPEG code table, and expected coefficients are derived from the block rules.
module tb_huffman_block_sequencer;

   localparam int COEF_W = 12;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic              bit_valid = 1'b0;
   logic              bit_data = 1'b0;
   logic              bit_ready;
   logic              hd_rst;
   logic              hd_ac_dc_flag;
   logic              hd_next_bit;
   logic              hd_is_new;
   logic [3:0]        hd_s_value;
   logic [3:0]        hd_r_value;
   logic              hd_done;
   logic              coef_valid;
   logic [5:0]        coef_index;
   logic [COEF_W-1:0] coef_value;
   logic              block_done;
   logic              error;

   always #5 clk = ~clk;

   huffman_block_sequencer #(.COEF_W(COEF_W), .MAX_CODE_LEN(16)) dut (
      .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid), .bit_data(bit_data),
      .bit_ready(bit_ready), .hd_rst(hd_rst), .hd_ac_dc_flag(hd_ac_dc_flag),
      .hd_next_bit(hd_next_bit), .hd_is_new(hd_is_new), .hd_s_value(hd_s_value),
      .hd_r_value(hd_r_value), .hd_done(hd_done), .coef_valid(coef_valid),
      .coef_index(coef_index), .coef_value(coef_value), .block_done(block_done),
      .error(error)
   );

   typedef struct { int len; int code; int dc; int s; int r; } code_t;
   typedef struct { int idx; int val; } coef_t;

   code_t tbl[$];
   coef_t exp_q[$];
   bit    bit_q[$];
   int    checks = 0;
   int    failures = 0;
   int    m_idx;
   int    m_end;          // 0 running, 1 block complete, 2 error
   int    stall_at = -1;
   int    stall_left = 0;
   int    ac_run[10]  = '{0, 0, 0, 0, 0, 1, 1, 2, 3, 4};
   int    ac_size[10] = '{1, 2, 3, 4, 5, 1, 2, 1, 1, 1};

   task automatic check(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         failures++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic add_code(input int len, input int code, input int dc, input int s, input int r);
      code_t c;
      c.len = len; c.code = code; c.dc = dc; c.s = s; c.r = r;
      tbl.push_back(c);
   endtask

   task automatic build_table();
      add_code(2, 'b00, 1, 0, 0);          add_code(3, 'b010, 1, 0, 1);
      add_code(3, 'b011, 1, 0, 2);         add_code(3, 'b100, 1, 0, 3);
      add_code(3, 'b101, 1, 0, 4);         add_code(3, 'b110, 1, 0, 5);
      add_code(4, 'b1110, 1, 0, 6);        add_code(5, 'b11110, 1, 0, 7);
      add_code(6, 'b111110, 1, 0, 8);      add_code(7, 'b1111110, 1, 0, 9);
      add_code(8, 'b11111110, 1, 0, 10);   add_code(9, 'b111111110, 1, 0, 11);
      add_code(10, 'b1111111110, 1, 0, 12);
      add_code(2, 'b00, 0, 0, 1);          add_code(2, 'b01, 0, 0, 2);
      add_code(3, 'b100, 0, 0, 3);         add_code(4, 'b1010, 0, 0, 0);
      add_code(4, 'b1011, 0, 0, 4);        add_code(5, 'b11010, 0, 0, 5);
      add_code(4, 'b1100, 0, 1, 1);        add_code(5, 'b11011, 0, 1, 2);
      add_code(5, 'b11100, 0, 2, 1);       add_code(6, 'b111010, 0, 3, 1);
      add_code(6, 'b111011, 0, 4, 1);      add_code(11, 'b11111111001, 0, 15, 0);
   endtask

   function automatic int find_code(input int dc, input int s, input int r);
      foreach (tbl[i]) if (tbl[i].dc == dc && tbl[i].s == s && tbl[i].r == r) return i;
      return -1;
   endfunction

   task automatic push_bits(input int code, input int len);
      for (int i = len - 1; i >= 0; i--) bit_q.push_back(1'((code >> i) & 1));
   endtask

   function automatic int rand_val(input int size);
      int mag;
      if (size == 0) return 0;
      mag = int'($urandom_range((1 << size) - 1, 1 << (size - 1)));
      return ($urandom_range(0, 1) == 1) ? mag : -mag;
   endfunction

   task automatic new_block();
      bit_q.delete();
      exp_q.delete();
      m_idx = 0;
      m_end = 0;
   endtask

   // Encode one symbol and advance the reference block model; ignored once the block has ended.
   task automatic add_sym(input int dc, input int run, input int size, input int val);
      int    k;
      coef_t c;
      if (m_end != 0) return;
      k = find_code(dc, run, size);
      push_bits(tbl[k].code, tbl[k].len);
      if (size > 0) push_bits((val >= 0) ? val : val + (1 << size) - 1, size);
      if (size > 11) begin
         m_end = 2;
      end else if (dc != 0) begin
         c.idx = 0; c.val = val; exp_q.push_back(c);
         m_idx = 1;
      end else if (run == 0 && size == 0) begin
         m_end = 1;
      end else if (run == 15 && size == 0) begin
         m_idx += 16;
         if (m_idx > 63) m_end = 2;
      end else if (m_idx + run > 63) begin
         m_end = 2;
      end else begin
         c.idx = m_idx + run; c.val = val; exp_q.push_back(c);
         m_idx = m_idx + run + 1;
         if (m_idx == 64) m_end = 1;
      end
   endtask

   // Behavioural Huffman_Decoder: accumulates fed bits and reports a match one cycle later.
   logic dec_new = 1'b0, dec_bit = 1'b0, dec_rst = 1'b0, dec_flag = 1'b0;
   int   acc_code = 0, acc_len = 0;

   always @(negedge clk) begin
      #2;
      dec_new  = hd_is_new;
      dec_bit  = hd_next_bit;
      dec_rst  = hd_rst;
      dec_flag = hd_ac_dc_flag;
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         hd_done    <= 1'b0;
         hd_s_value <= 4'd0;
         hd_r_value <= 4'd0;
         acc_code = 0;
         acc_len  = 0;
      end else begin
         hd_done <= 1'b0;
         if (dec_rst) begin
            acc_code = 0;
            acc_len  = 0;
         end else if (dec_new) begin
            acc_code = acc_code * 2 + int'(dec_bit);
            acc_len++;
            foreach (tbl[i]) begin
               if (tbl[i].dc == int'(dec_flag) && tbl[i].len == acc_len && tbl[i].code == acc_code) begin
                  hd_done    <= 1'b1;
                  hd_s_value <= 4'(tbl[i].s);
                  hd_r_value <= 4'(tbl[i].r);
               end
            end
         end
      end
   end

   coef_t mon_e;
   always @(negedge clk) begin
      #1;
      if (rst && coef_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL coef_unexpected: got idx %0d value %0d, required no coefficient",
                     coef_index, $signed(coef_value));
         end else begin
            mon_e = exp_q.pop_front();
            check("coef_index", int'(coef_index), mon_e.idx);
            check("coef_value", int'($signed(coef_value)), mon_e.val);
         end
      end
   end

   task automatic drive_cycle();
      bit stalled;
      @(negedge clk);
      stalled = 1'b0;
      if (stall_at >= 0 && bit_q.size() == stall_at) begin
         stall_left = 5;
         stall_at   = -1;
      end
      if (stall_left > 0) begin
         stall_left--;
         stalled   = 1'b1;
         bit_valid = 1'b0;
         bit_data  = 1'($urandom_range(0, 1));
      end else if (bit_q.size() > 0 && $urandom_range(0, 3) != 0) begin
         bit_valid = 1'b1;
         bit_data  = bit_q[0];
      end else begin
         bit_valid = 1'b0;
         bit_data  = 1'($urandom_range(0, 1));
      end
      #1;
      if (stalled) check("stall_is_new", int'(hd_is_new), 0);
      if (bit_valid && bit_ready) void'(bit_q.pop_front());
   endtask

   task automatic run_block(input string tag);
      bit got_done, got_err;
      int cyc;
      @(negedge clk);
      start     = 1'b1;
      bit_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      #1;
      check({tag, "_hd_rst_in_clr"}, int'(hd_rst), 1);
      check({tag, "_dc_flag_in_clr"}, int'(hd_ac_dc_flag), 1);
      check({tag, "_error_cleared"}, int'(error), 0);
      got_done = 1'b0;
      got_err  = 1'b0;
      cyc      = 0;
      while (!got_done && !got_err && cyc < 8000) begin
         drive_cycle();
         got_done = block_done;
         got_err  = error;
         cyc++;
      end
      check({tag, "_block_done"}, int'(got_done), int'(m_end == 1));
      check({tag, "_error"}, int'(got_err), int'(m_end == 2));
      check({tag, "_bits_left"}, bit_q.size(), 0);
      drive_cycle();
      check({tag, "_done_pulse_width"}, int'(block_done), 0);
      check({tag, "_idle_not_ready"}, int'(bit_ready), 0);
      check({tag, "_error_sticky"}, int'(error), int'(m_end == 2));
      check({tag, "_coefs_pending"}, exp_q.size(), 0);
      bit_valid = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int dsz, r, k;
      bit saw_done;
      build_table();
      repeat (3) @(negedge clk);
      #1;
      check("rst_bit_ready", int'(bit_ready), 0);
      check("rst_hd_rst", int'(hd_rst), 0);
      check("rst_hd_is_new", int'(hd_is_new), 0);
      check("rst_dc_flag", int'(hd_ac_dc_flag), 0);
      check("rst_coef_valid", int'(coef_valid), 0);
      check("rst_coef_value", int'(coef_value), 0);
      check("rst_block_done", int'(block_done), 0);
      check("rst_error", int'(error), 0);
      @(negedge clk);
      rst = 1'b1;

      // DC +2 then immediate EOB.
      new_block(); add_sym(1, 0, 2, 2); add_sym(0, 0, 0, 0);
      run_block("dc_eob");

      // DC +2, run1/size2 -2, EOB, with a 5-cycle bit stall in the middle of the AC code.
      new_block(); add_sym(1, 0, 2, 2); add_sym(0, 1, 2, -2); add_sym(0, 0, 0, 0);
      stall_at = 9;
      run_block("dc_ac_stall");

      // DC size 0 then run0/size1 with magnitude bit 0.
      new_block(); add_sym(1, 0, 0, 0); add_sym(0, 0, 1, -1); add_sym(0, 0, 0, 0);
      run_block("dc0_neg1");

      // Three ZRLs then EOB.
      new_block(); add_sym(1, 0, 0, 0);
      repeat (3) add_sym(0, 15, 0, 0);
      add_sym(0, 0, 0, 0);
      run_block("zrl3");

      // Four ZRLs overflow the index; the trailing symbol is never reached.
      new_block(); add_sym(1, 0, 0, 0);
      repeat (4) add_sym(0, 15, 0, 0);
      add_sym(0, 1, 1, 1);
      run_block("zrl_overflow");

      // All 63 AC positions filled, no EOB.
      new_block(); add_sym(1, 0, 11, -2047);
      while (m_end == 0) add_sym(0, 0, 1, rand_val(1));
      run_block("full_block");

      // DC size category 12 is outside the coefficient range.
      new_block(); add_sym(1, 0, 12, rand_val(12));
      run_block("dc_size12");

      // Sixteen code bits with no symbol match.
      new_block(); push_bits('hFFFF, 16); m_end = 2;
      run_block("code_too_long");

      for (int b = 0; b < 30; b++) begin
         new_block();
         dsz = int'($urandom_range(0, 11));
         add_sym(1, 0, dsz, rand_val(dsz));
         while (m_end == 0) begin
            r = int'($urandom_range(0, 99));
            if (r < 7) add_sym(0, 0, 0, 0);
            else if (r < 17) add_sym(0, 15, 0, 0);
            else begin
               k = int'($urandom_range(0, 9));
               add_sym(0, ac_run[k], ac_size[k], rand_val(ac_size[k]));
            end
         end
         run_block("random");
      end

      // Reset while magnitude bits of a size-11 DC coefficient are being collected.
      new_block(); add_sym(1, 0, 11, rand_val(11));
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 400 && bit_q.size() > 6; c++) drive_cycle();
      #2;
      rst = 1'b0;
      #1;
      check("midrst_bit_ready", int'(bit_ready), 0);
      check("midrst_hd_is_new", int'(hd_is_new), 0);
      check("midrst_dc_flag", int'(hd_ac_dc_flag), 0);
      check("midrst_hd_rst", int'(hd_rst), 0);
      check("midrst_coef_valid", int'(coef_valid), 0);
      check("midrst_error", int'(error), 0);
      new_block();
      bit_valid = 1'b0;
      saw_done  = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c == 3) rst = 1'b1;
         #1;
         saw_done |= block_done;
      end
      check("midrst_no_block_done", int'(saw_done), 0);
      new_block(); add_sym(1, 0, 3, -5); add_sym(0, 2, 1, 1); add_sym(0, 0, 0, 0);
      run_block("after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
